// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus: per-requester valid/address/data with one-hot ready.
// Requesters drive through master; the arbiter sits on slave.
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among requesters.
// Winner is registered into a one-cycle stage that also feeds read forwarding.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave req,
    input  logic                hold_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    input  logic [ADDR_W-1:0]   fwd_addr_a_i,
    input  logic [ADDR_W-1:0]   fwd_addr_b_i,
    output logic                fwd_hit_a_o,
    output logic                fwd_hit_b_o,
    output logic [DATA_W-1:0]   fwd_data_o,
    output logic [15:0]         conflict_cnt_o
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1   = PTR_W + 1;

    localparam logic [PW1-1:0]   NREQ_W = PW1'(NREQ);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] wr_data_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              accept;
    logic              contended;

    // Scan from ptr upward modulo NREQ; walking backwards leaves the first hit.
    always_comb begin
        logic [PW1-1:0] pos;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + PW1'(k);
            if (pos >= NREQ_W) begin
                pos = pos - NREQ_W;
            end
            if (req.req_valid[pos[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos[PTR_W-1:0];
            end
        end
    end

    // Pick the winner's address and data off the flattened request buses.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == gnt_idx) begin
                gnt_addr = req.req_addr[i*ADDR_W +: ADDR_W];
                gnt_data = req.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot ready, suppressed while stalled or in reset.
    always_comb begin
        accept        = gnt_found && !hold_i && !reset;
        req.req_ready = '0;
        if (accept) begin
            req.req_ready = NREQ'(1) << gnt_idx;
        end
    end

    // Two or more valid bits: clearing the lowest set bit leaves something.
    always_comb begin
        contended = (req.req_valid & (req.req_valid - NREQ'(1))) != '0;
    end

    // Next state for pointer, output stage and contention counter.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
            wr_en_d   = gnt_addr != '0;
            wr_addr_d = gnt_addr;
            wr_data_d = gnt_data;
        end
        if (contended && !hold_i && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers; reset discards any write sitting in the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Register-file drive and bypass hits against the pending write.
    always_comb begin
        wr_en_o        = wr_en_q;
        wr_addr_o      = wr_addr_q;
        wr_data_o      = wr_data_q;
        fwd_data_o     = wr_data_q;
        conflict_cnt_o = cnt_q;
        fwd_hit_a_o    = wr_en_q && (wr_addr_q == fwd_addr_a_i)
                         && (fwd_addr_a_i != '0);
        fwd_hit_b_o    = wr_en_q && (wr_addr_q == fwd_addr_b_i)
                         && (fwd_addr_b_i != '0);
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file. It shares the register file's single write port (enable, 5-bit address, 32-bit data) among NREQ write-back requesters, such as ALU, load and multiply results. It uses valid/ready handshakes and round-robin priority, and registers the winning write into a one-cycle output stage that drives the register file. It also exposes forwarding hits against that stage, so the read path can bypass a write that has not yet landed.

## Interface
- NREQ, 3, number of requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot grant; the write is accepted on the edge where valid and ready are both 1
- hold  in  1  freezes arbitration (pipeline stall); no grants while 1
- wr_en  out  1  register-file write enable (drives enc)
- wr_addr  out  ADDR_W  register-file write address (drives addrc)
- wr_data  out  DATA_W  register-file write data (drives datac)
- fwd_addr_a, fwd_addr_b  in  ADDR_W each  addresses being read on ports a/b
- fwd_hit_a, fwd_hit_b  out  1 each  pending write matches the read address
- fwd_data  out  DATA_W  equals wr_data
- conflict_cnt  out  16  saturating count of contended cycles

## Operation
- Round-robin pointer ptr (0..NREQ-1) marks the highest-priority requester.
- Grant goes to the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ. req_ready is combinational from req_valid, ptr, hold and reset.
- On an edge with a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr is unchanged.
- Output stage, on an accept edge:
  - wr_addr and wr_data load the granted requester's address and data.
  - wr_en loads 1 when the address is nonzero, and 0 when the address is 0.
  - A write to r0 is accepted (ready=1, consumed) but never reaches the register file.
- With no accept on an edge, wr_en loads 0. wr_addr and wr_data hold their last values.
- hold=1 forces req_ready=0 and freezes ptr. wr_en is 0 from the next edge on.
- fwd_hit_x = wr_en && (wr_addr == fwd_addr_x) && (fwd_addr_x != 0). This is purely combinational from the registered stage. fwd_data = wr_data.
- conflict_cnt increments on every edge where two or more req_valid bits are 1 and hold=0. It saturates at 0xFFFF and never wraps.
- req_valid, req_addr and req_data must stay stable while valid=1 and ready=0. The block does not check this.

## Timing
- Reset (asynchronous, immediate):
  - wr_en=0, wr_addr=0, wr_data=0, ptr=0, conflict_cnt=0.
  - req_ready=0 while reset=1.
  - fwd_hit_a and fwd_hit_b are 0 as a consequence of wr_en=0.
- Latency: an accept on edge N gives wr_en/wr_addr/wr_data valid from edge N to edge N+1. That is exactly one cycle per accepted write.
- Throughput: one write per cycle. With continuous contention, each requester is granted at least once every NREQ cycles.
- Simultaneous events:
  - hold rising in the same cycle as valid: no grant that cycle.
  - A write already in the output stage still completes; hold does not cancel it.
- Reset mid-write: the output stage is discarded immediately, wr_en drops asynchronously, and the pending request is not accepted.
- A single valid requester is granted in the same cycle regardless of ptr. There is no idle bubble.

## Test plan
- Reset with all valids asserted:
  - During reset: req_ready=000, wr_en=0, conflict_cnt=0.
  - First edge after release: grant to req0 (ptr=0), then wr_en=1 next cycle.
- Requesters 0, 1, 2 held valid with addrs 3, 4, 5 and data 0xA, 0xB, 0xC for 6 cycles:
  - Writes appear as (3,0xA), (4,0xB), (5,0xC), repeating.
  - conflict_cnt=6.
- Single requester 2 valid with addr 7, data 0x1234:
  - req_ready=100 in the same cycle.
  - Next cycle: wr_en=1, wr_addr=7, wr_data=0x1234.
- Requester 1 writes addr 0, data 0xFFFFFFFF: ready=010, then wr_en stays 0 and fwd_hit_a=0 with fwd_addr_a=0.
- Forwarding: stage holds addr 9 with wr_en=1.
  - fwd_addr_a=9, fwd_addr_b=8 gives fwd_hit_a=1, fwd_hit_b=0, fwd_data equal to the stage data.
- Two further checks:
  - hold=1 for 3 cycles with all valid: no ready, wr_en=0, ptr frozen, so the grant order resumes unchanged.
  - Reset asserted mid-stream: wr_en drops before the next clock edge.
